// File: rtl/pll_reset_seq.sv
// Post-PLL reset sequencer: glitch-filters lock, waits out VCO settling, then
// releases the domain resets in ascending order, restarting on lock loss or a software request.
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int NUM_RST     = 3,
  parameter int STAGGER     = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pll_locked,
  input  logic               sw_reset_req,
  output logic [NUM_RST-1:0] rst_n_out,
  output logic               ready,
  output logic [1:0]         state,
  output logic [7:0]         lock_lost_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] FILTER_LAST = CNT_WIDTH'(LOCK_FILTER - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   lock_s;
  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [NUM_RST-1:0]     rst_reg, rst_next, rel_hit;
  logic                   ready_reg, ready_next;
  logic [7:0]             lost_reg, lost_next;
  logic                   abort;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s  = sync_reg[SYNC_STAGES-1];
  assign cnt_inc = cnt_reg + 1'b1;

  // rel_hit[i] marks the edge at which the release counter reaches STAGGER*i.
  assign rel_hit[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_RST; gi++) begin : g_rel
      assign rel_hit[gi] = (cnt_inc == CNT_WIDTH'(STAGGER * gi));
    end
  endgenerate

  assign abort = (state_reg != WAIT_LOCK) && (!lock_s || sw_reset_req);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rst_next   = rst_reg;
    ready_next = ready_reg;
    lost_next  = lost_reg;
    if (abort) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
      rst_next   = '0;
      ready_next = 1'b0;
      if (!lock_s && lost_reg != 8'hFF) begin
        lost_next = lost_reg + 8'd1;
      end
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          rst_next   = '0;
          ready_next = 1'b0;
          if (sw_reset_req || !lock_s) begin
            cnt_next = '0;
          end else if (cnt_reg == FILTER_LAST) begin
            state_next = STABILIZE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        STABILIZE: begin
          if (cnt_reg == HOLD_LAST) begin
            cnt_next = '0;
            if (NUM_RST == 1) begin
              rst_next   = '1;
              ready_next = 1'b1;
              state_next = RUN;
            end else begin
              rst_next[0] = 1'b1;
              state_next  = RELEASE;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
        RELEASE: begin
          cnt_next = cnt_inc;
          rst_next = rst_reg | rel_hit;
          if (rel_hit[NUM_RST-1]) begin
            state_next = RUN;
            ready_next = 1'b1;
            cnt_next   = '0;
          end
        end
        RUN: begin
          rst_next   = '1;
          ready_next = 1'b1;
          cnt_next   = '0;
        end
        default: state_next = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= WAIT_LOCK;
      cnt_reg   <= '0;
      rst_reg   <= '0;
      ready_reg <= 1'b0;
      lost_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rst_reg   <= rst_next;
      ready_reg <= ready_next;
      lost_reg  <= lost_next;
    end
  end

  assign rst_n_out       = rst_reg;
  assign ready           = ready_reg;
  assign state           = state_reg;
  assign lock_lost_count = lost_reg;

endmodule
